// File: rtl/accum_controller.sv
// accum_controller: sequences a clear/load/add datapath that accumulates up
// to N_MAX operands into F and stops early when an add would reach 128.
module accum_controller #(
    parameter int unsigned N_MAX = 15
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       fgt127,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done,
    output logic       sat,
    output logic [3:0] count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_ACCUM,
        ST_DONE
    } state_t;

    localparam logic [3:0] COUNT_MAX = 4'(N_MAX);

    localparam logic [1:0] SEL_CLEAR = 2'b00;
    localparam logic [1:0] SEL_LOAD  = 2'b01;
    localparam logic [1:0] SEL_ADD   = 2'b10;
    localparam logic [1:0] SEL_HOLD  = 2'b11;

    state_t state;

    // Datapath command and operand handshake; reset forces hold with no beat taken
    always_comb begin
        sel      = SEL_HOLD;
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                ST_CLEAR: sel = SEL_CLEAR;
                ST_LOAD: begin
                    if (!stop && in_valid) begin
                        sel      = SEL_LOAD;
                        in_ready = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    // An overflowing beat is still consumed, but F is held.
                    if (!stop && in_valid) begin
                        in_ready = 1'b1;
                        if (!fgt127) begin
                            sel = SEL_ADD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Run sequencing with registered status outputs
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            sat   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CLEAR;
                        count <= '0;
                        sat   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (stop) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (in_valid) begin
                        count <= 4'd1;
                        if (COUNT_MAX == 4'd1) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (stop) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (in_valid) begin
                        if (fgt127) begin
                            sat   <= 1'b1;
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            count <= count + 4'd1;
                            if (count + 4'd1 == COUNT_MAX) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_controller.sv
// tb_accum_controller: three controller instances (N_MAX 15, 3, 1) sharing
// stimulus, each driving its own F datapath model; per-cycle vectors checked
// through a scoreboard queue.
module tb_accum_controller;

    typedef struct {
        int unsigned inst;
        logic        rst_i;
        logic        start_i;
        logic        stop_i;
        logic        iv_i;
        logic [7:0]  a_i;
        logic [1:0]  e_sel;
        logic        e_rdy;
        logic        e_busy;
        logic        e_done;
        logic        e_sat;
        logic [3:0]  e_cnt;
        int          e_f;
        string       name;
    } vec_t;

    logic             clock;
    logic             rst;
    logic             start;
    logic             stop;
    logic             in_valid;
    logic [7:0]       a;
    logic [2:0]       rdy_o;
    logic [2:0]       fgt;
    logic [2:0][1:0]  sel_o;
    logic [2:0]       busy_o;
    logic [2:0]       done_o;
    logic [2:0]       sat_o;
    logic [2:0][3:0]  count_o;
    logic [2:0][7:0]  f;
    logic [7:0]       sum8;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    accum_controller #(.N_MAX(15)) u_dut15 (
        .clock(clock), .rst(rst), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(rdy_o[0]), .fgt127(fgt[0]),
        .sel(sel_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .sat(sat_o[0]), .count(count_o[0])
    );

    accum_controller #(.N_MAX(3)) u_dut3 (
        .clock(clock), .rst(rst), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(rdy_o[1]), .fgt127(fgt[1]),
        .sel(sel_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .sat(sat_o[1]), .count(count_o[1])
    );

    accum_controller #(.N_MAX(1)) u_dut1 (
        .clock(clock), .rst(rst), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(rdy_o[2]), .fgt127(fgt[2]),
        .sel(sel_o[2]), .busy(busy_o[2]), .done(done_o[2]),
        .sat(sat_o[2]), .count(count_o[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath model: F register commanded by each controller's sel
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                f[i] <= '0;
            end else begin
                case (sel_o[i])
                    2'b00: f[i] <= '0;
                    2'b01: f[i] <= a;
                    2'b10: f[i] <= f[i] + a;
                    default: f[i] <= f[i];
                endcase
            end
        end
    end

    // Datapath status: bit 7 of A + F
    always_comb begin
        fgt  = '0;
        sum8 = '0;
        for (int i = 0; i < 3; i++) begin
            sum8   = f[i] + a;
            fgt[i] = sum8[7];
        end
    end

    function automatic vec_t mk(int unsigned inst, bit r, bit s, bit p, bit v,
                                int av, int es, bit er, bit eb, bit ed,
                                bit esat, int ec, int ef, string nm);
        vec_t t;
        t.inst = inst;  t.rst_i = r;  t.start_i = s;  t.stop_i = p;
        t.iv_i = v;     t.a_i = 8'(av);
        t.e_sel = 2'(es); t.e_rdy = er; t.e_busy = eb; t.e_done = ed;
        t.e_sat = esat;   t.e_cnt = 4'(ec); t.e_f = ef; t.name = nm;
        return t;
    endfunction

    task automatic chk(input string row, input string fld,
                       input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", row, fld, act, expv);
        end
    endtask

    // Drive one cycle of stimulus, then compare the popped expectation
    task automatic apply(input vec_t v);
        vec_t e;
        int unsigned i;
        rst      = v.rst_i;
        start    = v.start_i;
        stop     = v.stop_i;
        in_valid = v.iv_i;
        a        = v.a_i;
        exp_q.push_back(v);
        #2;
        e = exp_q.pop_front();
        i = e.inst;
        chk(e.name, "sel",      8'(sel_o[i]),   8'(e.e_sel));
        chk(e.name, "in_ready", 8'(rdy_o[i]),   8'(e.e_rdy));
        chk(e.name, "busy",     8'(busy_o[i]),  8'(e.e_busy));
        chk(e.name, "done",     8'(done_o[i]),  8'(e.e_done));
        chk(e.name, "sat",      8'(sat_o[i]),   8'(e.e_sat));
        chk(e.name, "count",    8'(count_o[i]), 8'(e.e_cnt));
        if (e.e_f >= 0) chk(e.name, "F", f[i], 8'(e.e_f));
        @(posedge clock);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; a = '0;
        @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; a = '0;
        repeat (2) @(posedge clock);
        #1;

        //        inst rst st sp iv  a  sel rdy bsy dn sat cnt  F
        tbl.push_back(mk(0, 1, 1, 1, 1, 5, 3, 0, 0, 0, 0, 0, -1, "reset_prio"));
        // 5,7,3 then stop
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, -1, "idle_start"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1, "clear"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 1, 1, 1, 0, 0, 0,  0, "load5"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 2, 1, 1, 0, 0, 1,  5, "add7"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 2, 1, 1, 0, 0, 2, 12, "add3"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 3, 0, 1, 0, 0, 3, 15, "stop"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 3, 15, "done"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 3, 15, "idle_hold"));
        // gaps, start while busy, stop with a valid beat, start held through DONE
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 3, -1, "idle_start2"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1, "clear_ign_start"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 1, 0, 0, 0,  0, "load_wait"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 1, 1, 1, 0, 0, 0,  0, "load2"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1,  2, "gap1"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 1, 0, 0, 1,  2, "gap2_start"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4, 2, 1, 1, 0, 0, 1,  2, "add4"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 2,  6, "gap3"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 2,  6, "gap4"));
        tbl.push_back(mk(0, 0, 0, 1, 1, 9, 3, 0, 1, 0, 0, 2,  6, "stop_valid"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 1, 0, 2,  6, "done_start"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 2,  6, "idle_restart"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1, "clear3"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 3, 0, 1, 0, 0, 0,  0, "load_stop"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0,  0, "done_empty"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0,  0, "idle3"));
        // all-15 operands: eight commit, the ninth saturates
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, -1, "sat_start"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1, "sat_clear"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 15, 1, 1, 1, 0, 0, 0, 0, "sat_load"));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 15, 2, 1, 1, 0, 0, k, 15 * k, "sat_add"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 15, 3, 1, 1, 0, 0, 8, 120, "sat_beat"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1, 8, 120, "sat_done"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 8, 120, "sat_idle"));
        // new run clears sat; reset mid-ACCUM at count 4; then a normal run
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 1, 8, -1, "r_start"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1, "r_clear"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, -1, "r_load"));
        for (int k = 1; k <= 3; k++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2, 1, 1, 0, 0, k, -1, "r_add"));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 3, 0, 1, 0, 0, 4, -1, "rst_in_accum"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, -1, "after_rst"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, -1, "post_start"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1, "post_clear"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 1, 1, 1, 0, 0, 0, -1, "post_load"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 3, 0, 1, 0, 0, 1,  5, "post_stop"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 1,  5, "post_done"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1,  5, "post_idle"));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // N_MAX=3: the third beat ends the run, the fourth is refused
        reset_all();
        apply(mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, -1, "n3_reset"));
        apply(mk(1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, -1, "n3_start"));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1, "n3_clear"));
        apply(mk(1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, -1, "n3_load"));
        apply(mk(1, 0, 0, 0, 1, 1, 2, 1, 1, 0, 0, 1,  1, "n3_add1"));
        apply(mk(1, 0, 0, 0, 1, 1, 2, 1, 1, 0, 0, 2,  2, "n3_add2"));
        apply(mk(1, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 3,  3, "n3_done"));
        apply(mk(1, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 3,  3, "n3_idle"));

        // N_MAX=1: the load alone completes the run
        reset_all();
        apply(mk(2, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, -1, "n1_start"));
        apply(mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1, "n1_clear"));
        apply(mk(2, 0, 0, 0, 1, 9, 1, 1, 1, 0, 0, 0, -1, "n1_load"));
        apply(mk(2, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 1,  9, "n1_done"));
        apply(mk(2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1,  9, "n1_idle"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_controller.md
ACCUM_CONTROLLER -- requirements
Module: accum_controller

Interface
REQ-001 Parameter: N_MAX, 15, maximum operands accepted per run; legal range 1..15.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-004 start  input  1  run request, sampled in IDLE only.
REQ-005 stop  input  1  early termination request, honoured in LOAD and ACCUM.
REQ-006 in_valid  input  1  operand A present at datapath input this cycle.
REQ-007 in_ready  output  1  controller consumes the operand this cycle (in_valid && in_ready = accepted beat).
REQ-008 fgt127  input  1  datapath status: bit 7 of (A + F) for current A and F.
REQ-009 sel  output  2  datapath command: 00 clear F, 01 load A, 10 add A, 11 hold F.
REQ-010 busy  output  1  high in CLEAR, LOAD, ACCUM.
REQ-011 done  output  1  one-cycle pulse in DONE.
REQ-012 sat  output  1  sticky: run ended because an add would reach >=128.
REQ-013 count  output  4  operands committed to F in the current/last run.

Function
REQ-014 States: IDLE, CLEAR, LOAD, ACCUM, DONE; Moore/Mealy mix as listed below; sel and in_ready combinational from state and inputs.
REQ-015 IDLE: sel=11, in_ready=0; start=1 -> CLEAR, clear count and sat on the same edge; start=0 -> stay.
REQ-016 CLEAR: sel=00, in_ready=0, exactly one cycle -> LOAD.
REQ-017 LOAD: stop=1 -> sel=11, in_ready=0, -> DONE (count stays 0).
REQ-018 LOAD: stop=0, in_valid=1 -> sel=01, in_ready=1, count=1; -> DONE if N_MAX=1, else -> ACCUM.
REQ-019 LOAD: stop=0, in_valid=0 -> sel=11, in_ready=0, stay.
REQ-020 ACCUM: stop=1 -> sel=11, in_ready=0 (beat not consumed even if in_valid), -> DONE.
REQ-021 ACCUM: in_valid=1, fgt127=0 -> sel=10, in_ready=1, count+1; -> DONE when count+1 == N_MAX, else stay.
REQ-022 ACCUM: in_valid=1, fgt127=1 -> sel=11, in_ready=1 (beat consumed and discarded), sat=1, count unchanged, -> DONE.
REQ-023 ACCUM: in_valid=0 -> sel=11, in_ready=0, stay.
REQ-024 DONE: sel=11, in_ready=0, done=1 for exactly one cycle, -> IDLE unconditionally.
REQ-025 start is ignored outside IDLE; a start held high through DONE begins a new run only when sampled in IDLE.
REQ-026 count never exceeds N_MAX and never wraps; sat and count hold their final values in IDLE until the next start.
REQ-027 fgt127 is ignored in IDLE, CLEAR, LOAD and DONE.
REQ-028 busy = 1 exactly in CLEAR, LOAD, ACCUM; done and busy are never high together.

Reset
REQ-029 rst=1 at a clock edge forces IDLE from any state, including mid-run; count=0, sat=0, done=0.
REQ-030 During and after reset until start: sel=11, in_ready=0, busy=0; rst has priority over start and stop.

Verification
REQ-031 N_MAX=15, start, operands 5,7,3 (in_valid each cycle), then stop -> sel 00,01,10,10,11; F=15; count=3; sat=0; done one cycle.
REQ-032 N_MAX=15, operands all 15 -> 8 beats committed, F=120; 9th beat fgt127=1 -> sel=11, in_ready=1, sat=1, count=8, done, F stays 120.
REQ-033 N_MAX=3, operands 1,1,1,1 -> third beat goes to DONE, F=3, count=3; fourth beat sees in_ready=0.
REQ-034 In ACCUM, in_valid gaps of 2 cycles -> sel=11 and count unchanged during gaps; stop with in_valid=1 -> in_ready=0, beat not consumed; start pulse while busy -> no effect.
REQ-035 rst asserted in ACCUM with count=4 -> next cycle IDLE, count=0, sat=0, sel=11, busy=0; subsequent start runs normally.
REQ-036 N_MAX=1, start, operand 9 -> sel 00,01,11; count=1; done one cycle after the load.
